// File: rtl/edge_detector_multi.sv
// Multi-channel synchronised, debounced edge detector.
// Ports: clk, rst, signal/mode/clear in; outedge/rise/fall/sticky/count out.
module edge_detector_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int COUNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           signal,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CHANNELS-1:0]           clear,
  output logic [CHANNELS-1:0]           outedge,
  output logic [CHANNELS-1:0]           rise,
  output logic [CHANNELS-1:0]           fall,
  output logic [CHANNELS-1:0]           sticky,
  output logic [CHANNELS*COUNT_W-1:0]   count
);

  typedef enum logic [2:0] {
    INIT,
    ZERO,
    PEND_UP,
    ONE,
    PEND_DN
  } state_t;

  localparam int WW = $clog2(SYNC_STAGES + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  logic [WW-1:0] wcnt;
  logic          warm;

  // warm-up counter: FSMs stay in INIT until sync chains are filled
  assign warm = (wcnt == WW'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (!warm) begin
      wcnt <= wcnt + WW'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sq;
    logic                   s;
    state_t                 st;
    state_t                 st_n;
    logic [DW-1:0]          dcnt;
    logic [DW-1:0]          dcnt_n;
    logic [DW-1:0]          dinc;
    logic                   rn;
    logic                   fn;
    logic                   on;
    logic [1:0]             m;
    logic                   rq;
    logic                   fq;
    logic                   oq;
    logic                   sq_st;
    logic [COUNT_W-1:0]     cq;

    assign s    = sq[SYNC_STAGES-1];
    assign m    = mode[2*i +: 2];
    assign dinc = dcnt + DW'(1);

    always_comb begin
      st_n   = st;
      dcnt_n = dcnt;
      rn     = 1'b0;
      fn     = 1'b0;
      case (st)
        INIT: begin
          if (warm) st_n = s ? ONE : ZERO;
        end
        ZERO: begin
          if (s) begin
            if (DEBOUNCE == 1) begin
              st_n = ONE;
              rn   = 1'b1;
            end else begin
              st_n   = PEND_UP;
              dcnt_n = DW'(1);
            end
          end
        end
        PEND_UP: begin
          if (!s) begin
            st_n   = ZERO;
            dcnt_n = '0;
          end else if (dinc == DW'(DEBOUNCE)) begin
            st_n   = ONE;
            rn     = 1'b1;
            dcnt_n = '0;
          end else begin
            dcnt_n = dinc;
          end
        end
        ONE: begin
          if (!s) begin
            if (DEBOUNCE == 1) begin
              st_n = ZERO;
              fn   = 1'b1;
            end else begin
              st_n   = PEND_DN;
              dcnt_n = DW'(1);
            end
          end
        end
        PEND_DN: begin
          if (s) begin
            st_n   = ONE;
            dcnt_n = '0;
          end else if (dinc == DW'(DEBOUNCE)) begin
            st_n   = ZERO;
            fn     = 1'b1;
            dcnt_n = '0;
          end else begin
            dcnt_n = dinc;
          end
        end
        default: begin
          st_n   = INIT;
          dcnt_n = '0;
        end
      endcase
    end

    assign on = (rn & m[0]) | (fn & m[1]);

    always_ff @(posedge clk) begin
      if (rst) begin
        sq    <= '0;
        st    <= INIT;
        dcnt  <= '0;
        rq    <= 1'b0;
        fq    <= 1'b0;
        oq    <= 1'b0;
        sq_st <= 1'b0;
        cq    <= '0;
      end else begin
        sq   <= {sq[SYNC_STAGES-2:0], signal[i]};
        st   <= st_n;
        dcnt <= dcnt_n;
        rq   <= rn;
        fq   <= fn;
        oq   <= on;
        // a new event beats a simultaneous clear
        if (on) sq_st <= 1'b1;
        else if (clear[i]) sq_st <= 1'b0;
        if (on) cq <= cq + COUNT_W'(1);
      end
    end

    assign rise[i]                  = rq;
    assign fall[i]                  = fq;
    assign outedge[i]               = oq;
    assign sticky[i]                = sq_st;
    assign count[i*COUNT_W +: COUNT_W] = cq;
  end

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed testbench for edge_detector_multi.
// Default parameters: 4 channels, 2 sync stages, debounce 4, 8-bit count.
module tb_edge_detector_multi;

  logic        clk;
  logic        rst;
  logic [3:0]  signal;
  logic [7:0]  mode;
  logic [3:0]  clear;
  logic [3:0]  outedge;
  logic [3:0]  rise;
  logic [3:0]  fall;
  logic [3:0]  sticky;
  logic [31:0] count;

  int errors;
  int checks;

  edge_detector_multi dut (
    .clk     (clk),
    .rst     (rst),
    .signal  (signal),
    .mode    (mode),
    .clear   (clear),
    .outedge (outedge),
    .rise    (rise),
    .fall    (fall),
    .sticky  (sticky),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] sig);
    signal = sig;
    clear  = 4'b0;
    rst    = 1'b1;
    tick();
    tick();
    checks++;
    if ({outedge, rise, fall, sticky} !== 16'h0 || count !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h/%h want 0/0",
               {outedge, rise, fall, sticky}, count);
    end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    signal = 4'b0101;
    mode   = 8'hFF;
    clear  = 4'b0;
    rst    = 1'b1;
    tick();
    tick();
    checks++;
    if ({outedge, rise, fall, sticky} !== 16'h0 || count !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got %h/%h want 0/0",
               {outedge, rise, fall, sticky}, count);
    end
    rst = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if ({rise, fall, outedge} !== 12'h0) begin
        errors++;
        $display("FAIL warmup_pulse t=%0d: got %h want 0",
                 t, {rise, fall, outedge});
      end
    end
    checks++;
    if (sticky !== 4'h0 || count !== 32'h0) begin
      errors++;
      $display("FAIL warmup_state: got %h/%h want 0/0", sticky, count);
    end
    // ch0 must have loaded ONE: releasing it yields a fall
    signal = 4'b0100;
    for (int t = 1; t <= 7; t++) begin
      logic [3:0] e;
      tick();
      e = (t == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (fall !== e || outedge !== e || rise !== 4'b0) begin
        errors++;
        $display("FAIL init_one t=%0d: got f=%b o=%b r=%b want f=o=%b",
                 t, fall, outedge, rise, e);
      end
    end
    checks++;
    if (count[7:0] !== 8'd1 || sticky !== 4'b0001) begin
      errors++;
      $display("FAIL init_one_cnt: got %0d/%b want 1/0001",
               count[7:0], sticky);
    end
  endtask

  task automatic test_clean_rise;
    do_reset(4'b0000);
    mode   = 8'b0000_0100;
    signal = 4'b0010;
    for (int t = 1; t <= 7; t++) begin
      logic [3:0] e;
      tick();
      e = (t == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if (rise !== e || outedge !== e || fall !== 4'b0) begin
        errors++;
        $display("FAIL clean_rise t=%0d: got r=%b o=%b f=%b want %b",
                 t, rise, outedge, fall, e);
      end
    end
    checks++;
    if (sticky !== 4'b0010 || count[15:8] !== 8'd1) begin
      errors++;
      $display("FAIL clean_rise_st: got %b/%0d want 0010/1",
               sticky, count[15:8]);
    end
  endtask

  task automatic test_glitch;
    do_reset(4'b0000);
    mode   = 8'hC0;
    signal = 4'b1000;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (t == 3) signal = 4'b0000;
      checks++;
      if ({rise, fall, outedge} !== 12'h0) begin
        errors++;
        $display("FAIL glitch t=%0d: got %h want 0",
                 t, {rise, fall, outedge});
      end
    end
    // back in ZERO with dcnt cleared: full latency again
    signal = 4'b1000;
    for (int t = 1; t <= 7; t++) begin
      logic [3:0] e;
      tick();
      e = (t == 6) ? 4'b1000 : 4'b0000;
      checks++;
      if (rise !== e || outedge !== e) begin
        errors++;
        $display("FAIL glitch_after t=%0d: got r=%b o=%b want %b",
                 t, rise, outedge, e);
      end
    end
  endtask

  task automatic test_both;
    do_reset(4'b0000);
    for (int k = 0; k < 2; k++) begin
      mode   = (k == 0) ? 8'h30 : 8'h20;
      signal = 4'b0100;
      for (int t = 1; t <= 20; t++) begin
        logic [3:0] er;
        logic [3:0] ef;
        logic [3:0] eo;
        tick();
        if (t == 8) signal = 4'b0000;
        er = (t == 6) ? 4'b0100 : 4'b0000;
        ef = (t == 14) ? 4'b0100 : 4'b0000;
        eo = (k == 0) ? (er | ef) : ef;
        checks++;
        if (rise !== er || fall !== ef || outedge !== eo) begin
          errors++;
          $display("FAIL both k=%0d t=%0d: got r=%b f=%b o=%b want %b %b %b",
                   k, t, rise, fall, outedge, er, ef, eo);
        end
      end
      checks++;
      if (count[23:16] !== ((k == 0) ? 8'd2 : 8'd3)) begin
        errors++;
        $display("FAIL both_cnt k=%0d: got %0d want %0d",
                 k, count[23:16], (k == 0) ? 2 : 3);
      end
    end
  endtask

  task automatic test_sticky_wrap;
    do_reset(4'b0000);
    mode = 8'h03;
    for (int n = 1; n <= 256; n++) begin
      logic [7:0] en;
      en = 8'(n);
      signal[0] = ~signal[0];
      for (int t = 1; t <= 6; t++) begin
        tick();
        if (n == 1 && t == 5) clear = 4'b0001;
      end
      checks++;
      if (outedge[0] !== 1'b1 || count[7:0] !== en) begin
        errors++;
        $display("FAIL wrap n=%0d: got o=%b c=%0d want 1/%0d",
                 n, outedge[0], count[7:0], en);
      end
      if (n == 1) begin
        checks++;
        if (sticky[0] !== 1'b1) begin
          errors++;
          $display("FAIL sticky_conflict: got %b want 1", sticky[0]);
        end
        tick();
        checks++;
        if (sticky[0] !== 1'b0) begin
          errors++;
          $display("FAIL sticky_clear: got %b want 0", sticky[0]);
        end
        clear = 4'b0000;
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(4'b0000);
    mode   = 8'h0C;
    signal = 4'b0010;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({outedge, rise, fall, sticky} !== 16'h0 || count !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got %h/%h want 0/0",
               {outedge, rise, fall, sticky}, count);
    end
    rst = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if (rise !== 4'b0 || outedge !== 4'b0) begin
        errors++;
        $display("FAIL mid_rewarm t=%0d: got r=%b o=%b want 0",
                 t, rise, outedge);
      end
    end
    signal = 4'b0000;
    for (int t = 1; t <= 7; t++) begin
      logic [3:0] e;
      tick();
      e = (t == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if (fall !== e || outedge !== e) begin
        errors++;
        $display("FAIL mid_fall t=%0d: got f=%b o=%b want %b",
                 t, fall, outedge, e);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    signal = 4'b0;
    mode   = 8'h0;
    clear  = 4'b0;
    test_reset();
    test_clean_rise();
    test_glitch();
    test_both();
    test_sticky_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
